yasac_io: RTL
=============

# yasac_io

Parametrised I/O port bank for YASAC-class processors, generalising the fixed eight-output/eight-input 8-bit port set into `NOUT` output and `NIN` input ports of `W` bits. It sits between the data unit's port-access path and the pins:
- output ports are registered;
- input ports are two-flop synchronised and edge-monitored;
- per-input change flags feed a maskable, registered interrupt request.

All port, flag and mask accesses use one address bus with a single-cycle registered read.

## Interface
- `W`, 8, port data width; `W >= NIN` required so the mask fits in one word.
- `NOUT`, 8, number of output ports; 1..16.
- `NIN`, 8, number of input ports; 1..16.
- `AW`, 5, address width; `NOUT + NIN + 2 <= 2**AW` required.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `addr`  in  AW  access address.
- `wr`  in  1  write strobe, one cycle per access.
- `wdata`  in  W  write data.
- `rd`  in  1  read strobe, one cycle per access.
- `rdata`  out  W  registered read data.
- `rvalid`  out  1  high the cycle after an accepted `rd`.
- `pout`  out  NOUT*W  output port registers; port i is bits [i*W +: W].
- `pin`  in  NIN*W  asynchronous input pins; port j is bits [j*W +: W].
- `irq`  out  1  registered interrupt request.

## Operation
Address map:
- 0..NOUT-1: output port registers, read/write.
- NOUT..NOUT+NIN-1: synchronised input ports, read-only.
- FLAG_ADDR = NOUT+NIN: change-flag vector, NIN bits, zero-extended; write-1-to-clear.
- MASK_ADDR = NOUT+NIN+1: interrupt mask, NIN bits, read/write.
- Any other address: writes ignored, reads return 0 with `rvalid` still asserted.

Writes:
- Write to an output port loads `wdata` into that port's register.
- Write to an input port address has no effect.

Input synchronisation and change detection:
- Each input bit passes through two flops, `s1` then `s2`.
- A third register `s3` holds the previous value of `s2`.
- Flag j sets when any bit of port j differs between `s2` and `s3`.

Reads:
- A read of input port j returns `s2` for that port.
- The same read clears flag j.

Flag collisions at one edge:
- Set beats clear, whether the clear comes from an input-port read or from a FLAG_ADDR write.

Interrupt:
- `irq` next = OR over j of (flag[j] AND mask[j]).

Simultaneous `rd` and `wr`:
- Both are performed.
- A read of the address being written returns the pre-write value.

Reset (asserted, asynchronously):
- `pout`, `rdata`, all sync stages, flags and mask go to 0.
- `rvalid` and `irq` go to 0.
- Any in-flight read is discarded: no `rvalid` follows reset release.

## Timing
Outputs and reads:
- A write at edge k is visible on `pout` immediately after edge k.
- `rd` sampled at edge k gives `rdata`/`rvalid` valid after edge k for exactly one cycle.
- `rdata` holds its value when `rvalid` is low.

Inputs and flags:
- A `pin` change stable before edge k appears in `s2` after edge k+1.
- The corresponding flag is set after edge k+2.
- `irq` rises after edge k+3.
- Input-port read latency from pin change is therefore 2 edges plus the 1-cycle read.

Back-to-back reads:
- Reads may issue every cycle, each giving its own `rvalid` pulse, with no stall.

Reset release:
- The first edge with `reset` high already accepts accesses.
- No flag sets from the zeroed sync chain unless `pin` is nonzero: a nonzero `pin` at release legitimately sets flags 3 edges later.

## Test plan
- Reset: drive `pin`=0, pulse `reset` low mid-cycle with `rd` pending -> all outputs 0 asynchronously; no `rvalid` after release.
- Output path (defaults): write 0xA5 to addr 3 -> `pout[31:24]`=0xA5 after that edge; read addr 3 -> `rdata`=0xA5 with `rvalid` one cycle later; write addr 30 -> no port changes; read addr 30 -> `rdata`=0x00, `rvalid`=1.
- Change flag and irq:
  - Set mask=0x04 via MASK_ADDR (17).
  - Change `pin` port 2 (addr 10) to 0x3C -> flag bit 2 set 3 edges after; `irq`=1 one edge later.
  - Read addr 10 -> `rdata`=0x3C, flag cleared, `irq` back to 0.
- Set-beats-clear: write 0x04 to FLAG_ADDR (16) on the same edge port 2 changes again -> flag 2 remains 1.
- Read/write collision: `rd` and `wr` to addr 0 in the same cycle (old 0x11, new 0x22) -> `rdata`=0x11, then `pout[7:0]`=0x22.
- Parametrisation: rerun the output-path and change-flag scenarios with W=16, NOUT=4, NIN=12, AW=5 -> mask spans 12 bits; FLAG_ADDR=16, MASK_ADDR=17.

Source files
------------

// File: rtl/yasac_io.sv
// yasac_io: parametrised bank of NOUT registered output ports and NIN synchronised input ports with change-flag interrupt.
// Latency: writes land on pout one edge later; reads return rdata/rvalid one edge after rd; pin changes reach the flags 3 edges later and irq 4 edges later.
// Backpressure: none; one access per cycle, reads may issue every cycle and always complete.
module yasac_io #(
  parameter int W    = 8,
  parameter int NOUT = 8,
  parameter int NIN  = 8,
  parameter int AW   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       addr,
  input  logic                wr,
  input  logic [W-1:0]        wdata,
  input  logic                rd,
  output logic [W-1:0]        rdata,
  output logic                rvalid,
  output logic [NOUT*W-1:0]   pout,
  input  logic [NIN*W-1:0]    pin,
  output logic                irq
);

  // Flag and mask registers sit directly above the input ports.
  localparam logic [AW-1:0] FLAG_ADDR = AW'(NOUT + NIN);
  localparam logic [AW-1:0] MASK_ADDR = AW'(NOUT + NIN + 1);

  // The mask is read and written as a single word, and every register needs an address.
  if (W < NIN || NOUT + NIN + 2 > 2 ** AW) begin : g_param_check
    $error("yasac_io: need W >= NIN and NOUT+NIN+2 <= 2**AW");
  end

  // s1/s2 form the synchroniser; s3 is the previous s2, used only for edge detection.
  logic [NIN*W-1:0] s1, s2, s3;
  logic [NIN-1:0]   flag;
  logic [NIN-1:0]   mask;
  logic [NIN-1:0]   chg;
  logic [NIN-1:0]   clr;
  logic [W-1:0]     rd_mux;

  // Read data selection from current register contents, so a read colliding with a write sees the old value.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NOUT; i++) begin
      if (addr == AW'(i)) rd_mux = pout[i*W +: W];
    end
    for (int j = 0; j < NIN; j++) begin
      if (addr == AW'(NOUT + j)) rd_mux = s2[j*W +: W];
    end
    if (addr == FLAG_ADDR) rd_mux = W'(flag);
    if (addr == MASK_ADDR) rd_mux = W'(mask);
  end

  // Per-port change detection and flag clear requests (input-port read or write-1-to-clear).
  always_comb begin
    chg = '0;
    clr = '0;
    for (int j = 0; j < NIN; j++) begin
      chg[j] = |(s2[j*W +: W] ^ s3[j*W +: W]);
      if (rd && addr == AW'(NOUT + j)) clr[j] = 1'b1;
    end
    if (wr && addr == FLAG_ADDR) clr = clr | wdata[NIN-1:0];
  end

  // Two-flop synchroniser plus history stage for every input bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Flags (a new change wins over a clear on the same edge), mask, and registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      flag <= chg | (flag & ~clr);
      if (wr && addr == MASK_ADDR) mask <= wdata[NIN-1:0];
      irq  <= |(flag & mask);
    end
  end

  // Output port registers; writes to any non-output address leave them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pout <= '0;
    end else if (wr) begin
      for (int i = 0; i < NOUT; i++) begin
        if (addr == AW'(i)) pout[i*W +: W] <= wdata;
      end
    end
  end

  // Registered read port; rdata holds its last value between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) rdata <= rd_mux;
    end
  end

endmodule
